// File: rtl/mem_bist_master.sv
// ----------------------------------------------------------------------------
// mem_bist_master
//
// Self-test initiator for the valid/ready single-port memory. On start it
// writes a selectable data pattern to every address 0..DEPTH-1. It then reads
// each word back and compares it with the same pattern. When the run ends it
// reports pass/fail, the number of mismatches and the first failing address.
//
// Every request uses a four-phase handshake. After a REQ state sees ready_i
// high, the matching GAP state waits for ready_i to drop before the next
// request is issued. The memory holds ready while valid is high, so this wait
// keeps one request from being counted twice.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-low reset
//   start_i      start a run (only taken in IDLE or DONE)
//   pattern_i    0=addr, 1=~addr, 2=checkerboard, 3=seed_i^addr
//   seed_i       seed for pattern 3, latched at start
//   valid_o      request to memory
//   wr_rd_en_o   1=write, 0=read
//   addr_o       request address
//   wdata_o      write data
//   rdata_i      read data from memory
//   ready_i      memory acknowledge
//   busy_o       run in progress
//   done_o       run finished, held until next start or reset
//   pass_o       done with no mismatch and no timeout
//   timeout_o    run aborted on a handshake timeout
//   err_count_o  read mismatches, saturating at DEPTH
//   fail_addr_o  first mismatching address, 0 if none
// ----------------------------------------------------------------------------
module mem_bist_master #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [1:0]            pattern_i,
   input  logic [WIDTH-1:0]      seed_i,
   output logic                  valid_o,
   output logic                  wr_rd_en_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [WIDTH-1:0]      wdata_o,
   input  logic [WIDTH-1:0]      rdata_i,
   input  logic                  ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  timeout_o,
   output logic [ADDR_WIDTH:0]   err_count_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WR_REQ = 3'd1;
   localparam logic [2:0] WR_GAP = 3'd2;
   localparam logic [2:0] RD_REQ = 3'd3;
   localparam logic [2:0] RD_GAP = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   ERR_MAX   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [TW-1:0]         WAIT_MAX  = TW'(TIMEOUT - 1);

   // The data word expected at address a for the selected pattern.
   function automatic logic [WIDTH-1:0] pattern_f(
      input logic [1:0]            sel,
      input logic [WIDTH-1:0]      seed,
      input logic [ADDR_WIDTH-1:0] a
   );
      logic [WIDTH+ADDR_WIDTH-1:0] a_wide;
      logic [WIDTH-1:0]            a_ext;
      logic [WIDTH-1:0]            cb;
      // Zero-extend the address, or truncate it, to the data width.
      a_wide = {{WIDTH{1'b0}}, a};
      a_ext  = a_wide[WIDTH-1:0];
      // Even addresses set the odd bits (..1010); odd addresses set the even bits.
      for (int i = 0; i < WIDTH; i++) begin
         cb[i] = ((i % 2) == 1) ^ a[0];
      end
      case (sel)
         2'd0:    pattern_f = a_ext;
         2'd1:    pattern_f = ~a_ext;
         2'd2:    pattern_f = cb;
         default: pattern_f = seed ^ a_ext;
      endcase
   endfunction

   logic [2:0]            state_q,   state_d;
   logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
   logic [TW-1:0]         wait_q,    wait_d;
   logic [1:0]            pat_q,     pat_d;
   logic [WIDTH-1:0]      seed_q,    seed_d;
   logic [ADDR_WIDTH:0]   err_q,     err_d;
   logic [ADDR_WIDTH-1:0] fail_q,    fail_d;
   logic                  timeout_q, timeout_d;

   logic [WIDTH-1:0] exp_data;
   logic             is_last;
   logic             timed_out;

   assign exp_data  = pattern_f(pat_q, seed_q, addr_q);
   assign is_last   = (addr_q == LAST_ADDR);
   assign timed_out = (wait_q == WAIT_MAX);

   always_comb begin
      // NOTE: every signal gets a default before the case statement. A path
      // that leaves a signal unassigned would otherwise infer a latch.
      state_d   = state_q;
      addr_d    = addr_q;
      wait_d    = wait_q;
      pat_d     = pat_q;
      seed_d    = seed_q;
      err_d     = err_q;
      fail_d    = fail_q;
      timeout_d = timeout_q;

      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d   = WR_REQ;
               addr_d    = '0;
               wait_d    = '0;
               pat_d     = pattern_i;
               seed_d    = seed_i;
               err_d     = '0;
               fail_d    = '0;
               timeout_d = 1'b0;
            end
         end

         WR_REQ: begin
            if (ready_i) begin
               state_d = WR_GAP;
               wait_d  = '0;
            end else if (timed_out) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         WR_GAP: begin
            if (!ready_i) begin
               wait_d = '0;
               if (is_last) begin
                  addr_d  = '0;
                  state_d = RD_REQ;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = WR_REQ;
               end
            end else if (timed_out) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         RD_REQ: begin
            if (ready_i) begin
               state_d = RD_GAP;
               wait_d  = '0;
               if (rdata_i != exp_data) begin
                  if (err_q == '0) begin
                     fail_d = addr_q;
                  end
                  if (err_q != ERR_MAX) begin
                     err_d = err_q + 1'b1;
                  end
               end
            end else if (timed_out) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         RD_GAP: begin
            if (!ready_i) begin
               wait_d = '0;
               if (is_last) begin
                  state_d = DONE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = RD_REQ;
               end
            end else if (timed_out) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: reset is synchronous and sampled only on the clock edge. Every
   // register is cleared, so a run that is interrupted leaves no partial result.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wait_q    <= '0;
         pat_q     <= '0;
         seed_q    <= '0;
         err_q     <= '0;
         fail_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments. Every register
         // then updates from values taken before the clock edge.
         state_q   <= state_d;
         addr_q    <= addr_d;
         wait_q    <= wait_d;
         pat_q     <= pat_d;
         seed_q    <= seed_d;
         err_q     <= err_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
      end
   end

   // Request fields are decoded from registered state only. They stay stable
   // for as long as a REQ state waits for ready_i.
   assign valid_o     = (state_q == WR_REQ) || (state_q == RD_REQ);
   assign wr_rd_en_o  = (state_q == WR_REQ);
   assign addr_o      = addr_q;
   assign wdata_o     = exp_data;
   assign busy_o      = (state_q == WR_REQ) || (state_q == WR_GAP) ||
                        (state_q == RD_REQ) || (state_q == RD_GAP);
   assign done_o      = (state_q == DONE);
   assign pass_o      = (state_q == DONE) && (err_q == '0) && !timeout_q;
   assign timeout_o   = timeout_q;
   assign err_count_o = err_q;
   assign fail_addr_o = fail_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// ----------------------------------------------------------------------------
// tb_mem_bist_master
//
// Directed bench for mem_bist_master with WIDTH=8, DEPTH=16 and TIMEOUT=8.
// The bench includes a memory model with a 1-cycle ready response. Ready
// follows valid one cycle later. The model performs the access on the first
// edge where valid is high. Chosen addresses can be marked to return corrupted
// read data (bit 0 flipped), and ready can be forced stuck low.
// ----------------------------------------------------------------------------
module tb_mem_bist_master;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic [1:0] pattern_i;
   logic [7:0] seed_i;
   logic       valid_o;
   logic       wr_rd_en_o;
   logic [3:0] addr_o;
   logic [7:0] wdata_o;
   logic [7:0] rdata_i;
   logic       ready_i;
   logic       busy_o;
   logic       done_o;
   logic       pass_o;
   logic       timeout_o;
   logic [4:0] err_count_o;
   logic [3:0] fail_addr_o;

   // Memory model state
   logic [7:0]  mem [16];
   logic [15:0] bad_addr;
   logic        stuck;
   int          wr_cnt = 0;
   int          rd_cnt = 0;

   int tests = 0;
   int fails = 0;
   int wr_base, rd_base, cycles;
   logic found;

   mem_bist_master #(
      .WIDTH   (8),
      .DEPTH   (16),
      .TIMEOUT (8)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .pattern_i   (pattern_i),
      .seed_i      (seed_i),
      .valid_o     (valid_o),
      .wr_rd_en_o  (wr_rd_en_o),
      .addr_o      (addr_o),
      .wdata_o     (wdata_o),
      .rdata_i     (rdata_i),
      .ready_i     (ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .pass_o      (pass_o),
      .timeout_o   (timeout_o),
      .err_count_o (err_count_o),
      .fail_addr_o (fail_addr_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (!rst_i) begin
         ready_i <= 1'b0;
         rdata_i <= 8'h00;
      end else begin
         ready_i <= valid_o && !stuck;
         if (valid_o && !ready_i && !stuck) begin
            if (wr_rd_en_o) begin
               mem[addr_o] <= wdata_o;
               wr_cnt      <= wr_cnt + 1;
            end else begin
               rdata_i <= mem[addr_o] ^ (bad_addr[addr_o] ? 8'h01 : 8'h00);
               rd_cnt  <= rd_cnt + 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Pulse start for one cycle and snapshot the model's access counters.
   task automatic start_run(input logic [1:0] pat, input logic [7:0] seed);
      pattern_i = pat;
      seed_i    = seed;
      wr_base   = wr_cnt;
      rd_base   = rd_cnt;
      start_i   = 1'b1;
      tick();
      start_i   = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (!done_o && n < 400) begin
         tick();
         n++;
      end
      if (!done_o) check({tag, "_done_wait"}, 32'(done_o), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i     = 1'b0;
      start_i   = 1'b0;
      pattern_i = 2'd0;
      seed_i    = 8'h00;
      stuck     = 1'b0;
      bad_addr  = 16'h0000;
      tick(); tick(); tick();

      // Reset state
      check("rst_valid",   32'(valid_o), 0);
      check("rst_busy",    32'(busy_o), 0);
      check("rst_done",    32'(done_o), 0);
      check("rst_pass",    32'(pass_o), 0);
      check("rst_timeout", 32'(timeout_o), 0);
      check("rst_err",     32'(err_count_o), 0);
      check("rst_fail",    32'(fail_addr_o), 0);
      rst_i = 1'b1;
      tick();

      // Pattern 0 on a good memory: 16 writes, then 16 reads, 4 cycles per access
      start_run(2'd0, 8'h00);
      check("p0_busy",  32'(busy_o), 1);
      check("p0_valid", 32'(valid_o), 1);
      check("p0_wr",    32'(wr_rd_en_o), 1);
      check("p0_addr",  32'(addr_o), 0);
      wait_done("p0", cycles);
      check("p0_cycles", 32'(cycles), 128);
      check("p0_done",   32'(done_o), 1);
      check("p0_pass",   32'(pass_o), 1);
      check("p0_err",    32'(err_count_o), 0);
      check("p0_writes", 32'(wr_cnt - wr_base), 16);
      check("p0_reads",  32'(rd_cnt - rd_base), 16);
      check("p0_mem5",   32'(mem[5]), 32'h05);
      check("p0_mem15",  32'(mem[15]), 32'h0F);
      check("p0_idle",   32'(busy_o), 0);

      // One corrupted word at address 5
      bad_addr = 16'h0020;
      start_run(2'd0, 8'h00);
      wait_done("e1", cycles);
      check("e1_err",  32'(err_count_o), 1);
      check("e1_fail", 32'(fail_addr_o), 5);
      check("e1_pass", 32'(pass_o), 0);
      check("e1_done", 32'(done_o), 1);

      // Corruption at 3 and 9 with pattern 1 (~addr)
      bad_addr = 16'h0208;
      start_run(2'd1, 8'h00);
      check("e2_start_err", 32'(err_count_o), 0);
      wait_done("e2", cycles);
      check("e2_err",  32'(err_count_o), 2);
      check("e2_fail", 32'(fail_addr_o), 3);
      check("e2_pass", 32'(pass_o), 0);
      check("e2_mem3", 32'(mem[3]), 32'hFC);
      bad_addr = 16'h0000;

      // Checkerboard
      start_run(2'd2, 8'h00);
      check("p2_wdata0", 32'(wdata_o), 32'hAA);
      wait_done("p2", cycles);
      check("p2_mem0",  32'(mem[0]), 32'hAA);
      check("p2_mem1",  32'(mem[1]), 32'h55);
      check("p2_mem14", 32'(mem[14]), 32'hAA);
      check("p2_pass",  32'(pass_o), 1);
      check("p2_fail",  32'(fail_addr_o), 0);

      // Seed xor addr with seed F0
      start_run(2'd3, 8'hF0);
      seed_i = 8'h00;  // the seed is latched at start, so this change must not matter
      wait_done("p3", cycles);
      check("p3_mem2",  32'(mem[2]), 32'hF2);
      check("p3_mem15", 32'(mem[15]), 32'hFF);
      check("p3_pass",  32'(pass_o), 1);

      // start_i held high in DONE restarts on the next cycle
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("rs_busy", 32'(busy_o), 1);
      check("rs_done", 32'(done_o), 0);
      wait_done("rs", cycles);
      check("rs_pass", 32'(pass_o), 1);

      // ready_i stuck low: 8-cycle wait in WR_REQ, then abort
      stuck = 1'b1;
      start_run(2'd0, 8'h00);
      repeat (7) tick();
      check("to_valid_hold", 32'(valid_o), 1);
      check("to_busy_hold",  32'(busy_o), 1);
      tick();
      check("to_valid",   32'(valid_o), 0);
      check("to_timeout", 32'(timeout_o), 1);
      check("to_done",    32'(done_o), 1);
      check("to_pass",    32'(pass_o), 0);
      stuck = 1'b0;

      // Reset during WR_REQ at address 7
      start_run(2'd0, 8'h00);
      check("mr_timeout_clr", 32'(timeout_o), 0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (valid_o && wr_rd_en_o && addr_o == 4'd7) found = 1'b1;
         else tick();
      end
      check("mr_reach_addr7", 32'(found), 1);
      rst_i = 1'b0;
      tick();
      check("mr_valid", 32'(valid_o), 0);
      check("mr_busy",  32'(busy_o), 0);
      check("mr_done",  32'(done_o), 0);
      check("mr_addr",  32'(addr_o), 0);
      rst_i = 1'b1;
      tick();

      // start_i pulse during the read phase is ignored
      start_run(2'd0, 8'h00);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (valid_o && !wr_rd_en_o && addr_o == 4'd4) found = 1'b1;
         else tick();
      end
      check("sb_reach_rd4", 32'(found), 1);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("sb_still_read", 32'(wr_rd_en_o), 0);
      wait_done("sb", cycles);
      check("sb_writes", 32'(wr_cnt - wr_base), 16);
      check("sb_reads",  32'(rd_cnt - rd_base), 16);
      check("sb_pass",   32'(pass_o), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
